// File: rtl/mdr_mem_unit_if.sv
// mdr_mem_unit_if
//   Bundles the internal-bus side and the memory side of the MDR stage.
//   The "slave" modport is the MDR unit's view. The "master" modport is the
//   view of the surrounding datapath/memory that drives requests and
//   returns acks.
//   Signals:
//     BusMuxOut  internal bus value (load source for MDRin)
//     MDRin      load MDR from BusMuxOut
//     Read       request memory read into MDR
//     Write      request memory write of MDR
//     mar_addr   address from MAR, sampled when a request is accepted
//     mem_rdata  memory read data, valid with mem_ack
//     mem_ack    memory completion strobe
//     mem_addr   registered memory address
//     mem_wdata  registered write data
//     mem_rd     read strobe
//     mem_wr     write strobe
//     busy       transaction outstanding
//     done       one-cycle completion pulse
//     error      sticky timeout flag
//     MDR_q      MDR contents
interface mdr_mem_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic [DATA_W-1:0] BusMuxOut;
  logic              MDRin;
  logic              Read;
  logic              Write;
  logic [ADDR_W-1:0] mar_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic              busy;
  logic              done;
  logic              error;
  logic [DATA_W-1:0] MDR_q;

  modport slave (
    input  BusMuxOut, MDRin, Read, Write, mar_addr, mem_rdata, mem_ack,
    output mem_addr, mem_wdata, mem_rd, mem_wr, busy, done, error, MDR_q
  );

  modport master (
    output BusMuxOut, MDRin, Read, Write, mar_addr, mem_rdata, mem_ack,
    input  mem_addr, mem_wdata, mem_rd, mem_wr, busy, done, error, MDR_q
  );
endinterface

// File: rtl/mdr_mem_unit.sv
// mdr_mem_unit
//   Memory Data Register stage with a single-outstanding memory handshake.
//   MDR is loaded either from the internal bus (MDRin) or from memory (Read),
//   and memory writes are driven from MDR (Write). A wait-state counter
//   aborts a transaction with a sticky error if mem_ack never arrives.
//   Ports:
//     clock  system clock, rising edge
//     clear  asynchronous active-high reset
//     bus    mdr_mem_unit_if.slave, request/memory handshake and MDR output
//   All interface outputs come straight from registers.
module mdr_mem_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic           clock,
  input  logic           clear,
  mdr_mem_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] mdr_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              rd_reg;
  logic              wr_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              error_reg;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      mdr_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rd_reg    <= 1'b0;
      wr_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only the ack branches raise it.
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.Read) begin
            // Read wins over MDRin: MDR will be overwritten by memory data.
            addr_reg  <= bus.mar_addr;
            rd_reg    <= 1'b1;
            busy_reg  <= 1'b1;
            error_reg <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= RD_WAIT;
          end else if (bus.Write) begin
            // Write data is the MDR value before any same-edge bus load.
            addr_reg  <= bus.mar_addr;
            wdata_reg <= mdr_reg;
            wr_reg    <= 1'b1;
            busy_reg  <= 1'b1;
            error_reg <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= WR_WAIT;
            if (bus.MDRin) begin
              mdr_reg <= bus.BusMuxOut;
            end
          end else if (bus.MDRin) begin
            mdr_reg <= bus.BusMuxOut;
          end
        end

        RD_WAIT: begin
          if (bus.mem_ack) begin
            mdr_reg   <= bus.mem_rdata;
            rd_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end else if (cnt_reg == CNT_LAST) begin
            rd_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            error_reg <= 1'b1;
            state_reg <= IDLE;
          end else begin
            // Increment stops at CNT_LAST, so the counter never wraps.
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        WR_WAIT: begin
          if (bus.mem_ack) begin
            wr_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end else if (cnt_reg == CNT_LAST) begin
            wr_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            error_reg <= 1'b1;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        default: begin
          // Unreachable encoding: drop back to a quiet idle.
          rd_reg    <= 1'b0;
          wr_reg    <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.mem_rd    = rd_reg;
  assign bus.mem_wr    = wr_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.error     = error_reg;
  assign bus.MDR_q     = mdr_reg;

endmodule

// File: tb/tb_mdr_mem_unit.sv
// tb_mdr_mem_unit
//   Self-checking bench for mdr_mem_unit. A small reference model (expected
//   MDR contents and error flag) is updated from transaction outcomes; each
//   scenario task drives stimulus and compares outputs after every edge.
module tb_mdr_mem_unit;

  localparam int TIMEOUT = 15;

  logic clock;
  logic clear;

  mdr_mem_unit_if #(.DATA_W(32), .ADDR_W(9)) bus ();

  mdr_mem_unit #(.DATA_W(32), .ADDR_W(9), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state.
  logic [31:0] m_mdr;
  logic        m_error;

  // {busy, done, mem_rd, mem_wr, error}
  logic [4:0] st;
  assign st = {bus.busy, bus.done, bus.mem_rd, bus.mem_wr, bus.error};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Read    = 1'b0;
    bus.Write   = 1'b0;
    bus.MDRin   = 1'b0;
    bus.mem_ack = 1'b0;
  endtask

  // Read transaction. k = wait edge on which ack is presented (1-based);
  // k outside 1..TIMEOUT means no ack. noise asserts Write/MDRin while busy.
  task automatic do_read(input logic [8:0] addr, input logic [31:0] rdata,
                         input int k, input bit mdrin, input logic [31:0] busval,
                         input bit noise);
    bit acked;
    logic [4:0] exp;
    bus.Read = 1'b1;
    bus.mar_addr = addr;
    bus.MDRin = mdrin;
    bus.BusMuxOut = busval;
    tick();
    idle_inputs();
    tests_run++;
    if (st !== 5'b10100 || bus.mem_addr !== addr || bus.MDR_q !== m_mdr) begin
      tests_failed++;
      $display("FAIL rd_accept: status=%b addr=%h mdr=%h, want status=10100 addr=%h mdr=%h",
               st, bus.mem_addr, bus.MDR_q, addr, m_mdr);
    end
    acked = 0;
    for (int e = 1; e <= TIMEOUT && !acked; e++) begin
      if (e == k) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = rdata;
      end else begin
        bus.mem_rdata = $urandom;
      end
      if (noise) begin
        bus.Write = 1'b1;
        bus.MDRin = 1'b1;
        bus.BusMuxOut = $urandom;
        bus.mar_addr = 9'($urandom);
      end
      tick();
      idle_inputs();
      if (e == k) begin
        acked = 1;
        m_mdr = rdata;
        m_error = 1'b0;
        exp = 5'b01000;
      end else if (e == TIMEOUT) begin
        m_error = 1'b1;
        exp = 5'b00001;
      end else begin
        exp = 5'b10100;
      end
      tests_run++;
      if (st !== exp || bus.MDR_q !== m_mdr) begin
        tests_failed++;
        $display("FAIL rd_wait edge %0d: status=%b mdr=%h, want status=%b mdr=%h",
                 e, st, bus.MDR_q, exp, m_mdr);
      end
    end
    tick();
    tests_run++;
    if (st !== {4'b0000, m_error} || bus.MDR_q !== m_mdr) begin
      tests_failed++;
      $display("FAIL rd_after: status=%b mdr=%h, want status=%b mdr=%h",
               st, bus.MDR_q, {4'b0000, m_error}, m_mdr);
    end
  endtask

  task automatic do_write(input logic [8:0] addr, input int k, input bit mdrin,
                          input logic [31:0] busval, input bit noise);
    bit acked;
    logic [4:0] exp;
    logic [31:0] old_mdr;
    old_mdr = m_mdr;
    bus.Write = 1'b1;
    bus.mar_addr = addr;
    bus.MDRin = mdrin;
    bus.BusMuxOut = busval;
    tick();
    idle_inputs();
    if (mdrin) m_mdr = busval;
    tests_run++;
    if (st !== 5'b10010 || bus.mem_addr !== addr || bus.mem_wdata !== old_mdr ||
        bus.MDR_q !== m_mdr) begin
      tests_failed++;
      $display("FAIL wr_accept: status=%b addr=%h wdata=%h mdr=%h, want status=10010 addr=%h wdata=%h mdr=%h",
               st, bus.mem_addr, bus.mem_wdata, bus.MDR_q, addr, old_mdr, m_mdr);
    end
    acked = 0;
    for (int e = 1; e <= TIMEOUT && !acked; e++) begin
      bus.mem_rdata = $urandom;
      if (e == k) bus.mem_ack = 1'b1;
      if (noise) begin
        bus.Read = 1'b1;
        bus.MDRin = 1'b1;
        bus.BusMuxOut = $urandom;
      end
      tick();
      idle_inputs();
      if (e == k) begin
        acked = 1;
        m_error = 1'b0;
        exp = 5'b01000;
      end else if (e == TIMEOUT) begin
        m_error = 1'b1;
        exp = 5'b00001;
      end else begin
        exp = 5'b10010;
      end
      tests_run++;
      if (st !== exp || bus.MDR_q !== m_mdr) begin
        tests_failed++;
        $display("FAIL wr_wait edge %0d: status=%b mdr=%h, want status=%b mdr=%h",
                 e, st, bus.MDR_q, exp, m_mdr);
      end
    end
    tick();
    tests_run++;
    if (st !== {4'b0000, m_error} || bus.MDR_q !== m_mdr) begin
      tests_failed++;
      $display("FAIL wr_after: status=%b mdr=%h, want status=%b mdr=%h",
               st, bus.MDR_q, {4'b0000, m_error}, m_mdr);
    end
  endtask

  task automatic do_load(input logic [31:0] val);
    bus.MDRin = 1'b1;
    bus.BusMuxOut = val;
    tick();
    idle_inputs();
    m_mdr = val;
    tests_run++;
    if (st !== {4'b0000, m_error} || bus.MDR_q !== m_mdr) begin
      tests_failed++;
      $display("FAIL mdrin_load: status=%b mdr=%h, want status=%b mdr=%h",
               st, bus.MDR_q, {4'b0000, m_error}, m_mdr);
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    idle_inputs();
    bus.BusMuxOut = 32'hFFFF_FFFF;
    bus.mar_addr = 9'h1FF;
    bus.mem_rdata = 32'hFFFF_FFFF;
    #2;
    tick();
    tests_run++;
    if (st !== 5'b00000 || bus.MDR_q !== 32'd0 || bus.mem_addr !== 9'd0 || bus.mem_wdata !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_state: status=%b mdr=%h addr=%h wdata=%h, want all zero",
               st, bus.MDR_q, bus.mem_addr, bus.mem_wdata);
    end
    #2 clear = 1'b0;
    m_mdr = 32'd0;
    m_error = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    do_load(32'hA5A5_5A5A);
    bus.Read = 1'b1;
    bus.mar_addr = 9'h033;
    tick();
    idle_inputs();
    tick();
    tick();
    tests_run++;
    if (st !== 5'b10100) begin
      tests_failed++;
      $display("FAIL pre_clear_wait: status=%b, want 10100", st);
    end
    #2 clear = 1'b1;
    #1;
    tests_run++;
    if (st !== 5'b00000 || bus.MDR_q !== 32'd0 || bus.mem_addr !== 9'd0) begin
      tests_failed++;
      $display("FAIL async_clear: status=%b mdr=%h addr=%h, want all zero",
               st, bus.MDR_q, bus.mem_addr);
    end
    #1 clear = 1'b0;
    m_mdr = 32'd0;
    m_error = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ack = (i == 0);
      tick();
      idle_inputs();
      tests_run++;
      if (st !== 5'b00000 || bus.MDR_q !== 32'd0) begin
        tests_failed++;
        $display("FAIL post_clear %0d: status=%b mdr=%h, want 00000 mdr=0", i, st, bus.MDR_q);
      end
    end
  endtask

  task automatic test_mdrin();
    do_load(32'd16);
    // mem_ack while idle must be ignored.
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    tests_run++;
    if (st !== 5'b00000 || bus.MDR_q !== 32'd16) begin
      tests_failed++;
      $display("FAIL idle_ack: status=%b mdr=%h, want 00000 mdr=10", st, bus.MDR_q);
    end
  endtask

  task automatic test_read();
    do_read(9'h005, 32'd32, 1, 1'b0, 32'd0, 1'b0);
    // Read with same-edge MDRin: memory data wins.
    do_read(9'h0A7, 32'h1234_5678, 2, 1'b1, 32'h0BAD_0BAD, 1'b0);
  endtask

  task automatic test_write();
    do_load(32'd16);
    do_write(9'h0C3, 3, 1'b1, 32'd7, 1'b0);
  endtask

  task automatic test_timeout();
    do_read(9'h011, 32'h5555_AAAA, 0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    tests_run++;
    if (bus.error !== 1'b1) begin
      tests_failed++;
      $display("FAIL error_sticky: error=%b, want 1", bus.error);
    end
    do_read(9'h012, 32'h7777_0001, TIMEOUT, 1'b0, 32'd0, 1'b0);
    do_write(9'h013, 0, 1'b0, 32'd0, 1'b0);
    do_write(9'h014, TIMEOUT, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic test_ignore_busy();
    do_read(9'h020, 32'hCAFE_F00D, 4, 1'b0, 32'd0, 1'b1);
    do_write(9'h021, 5, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic test_random();
    int op;
    int k;
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 2));
      k = int'($urandom_range(1, 18));
      case (op)
        0: do_read(9'($urandom), $urandom, k, 1'($urandom), $urandom, 1'($urandom));
        1: do_write(9'($urandom), k, 1'($urandom), $urandom, 1'($urandom));
        default: do_load($urandom);
      endcase
    end
  endtask

  initial begin
    idle_inputs();
    bus.BusMuxOut = '0;
    bus.mar_addr = '0;
    bus.mem_rdata = '0;
    clear = 1'b0;
    test_reset();
    test_reset_mid_read();
    test_mdrin();
    test_read();
    test_write();
    test_timeout();
    test_ignore_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
